// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types and command field layout
// for the I2C access arbiter.
package i2c_arb_pkg;

  localparam int CMD_W = 33;

  localparam int WDATA_LSB = 0;
  localparam int REG_LSB   = 8;
  localparam int RW_BIT    = 24;
  localparam int DEV_LSB   = 25;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/i2c_access_arbiter.sv
// i2c_access_arbiter: two-requester round-robin front end for
// a single-transaction I2C engine, with per-transaction timeout.
module i2c_access_arbiter #(
  parameter int TIMEOUT_CYC = 2000000,
  parameter int CMD_W       = i2c_arb_pkg::CMD_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_done,
  input  logic             req0_valid,
  input  logic [CMD_W-1:0] req0_cmd,
  output logic             req0_ready,
  output logic             req0_done,
  output logic             req0_err,
  output logic [7:0]       req0_rdata,
  input  logic             req1_valid,
  input  logic [CMD_W-1:0] req1_cmd,
  output logic             req1_ready,
  output logic             req1_done,
  output logic             req1_err,
  output logic [7:0]       req1_rdata,
  output logic             eng_valid,
  output logic [CMD_W-1:0] eng_cmd,
  input  logic             eng_ready,
  input  logic             eng_done,
  input  logic             eng_ack_err,
  input  logic [7:0]       eng_rdata,
  output logic             eng_abort
);
  import i2c_arb_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYC - 2);

  state_e           state_q;
  logic             owner_q;
  logic             lg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             eng_valid_q;
  logic [CMD_W-1:0] eng_cmd_q;
  logic             eng_abort_q;
  logic             done0_q;
  logic             done1_q;
  logic             err0_q;
  logic             err1_q;
  logic [7:0]       rd0_q;
  logic [7:0]       rd1_q;

  logic       arb1;
  logic       can_acc;
  logic       busy;
  logic       fin_done;
  logic       fin_tmo;
  logic       fin_err;
  logic [7:0] fin_rd;

  // req1 wins if it is alone, or if both ask and req0 went last
  assign arb1 = req1_valid & (~req0_valid | ~lg_q);
  assign can_acc = rstn & cfg_done & (state_q == S_IDLE);
  assign req0_ready = can_acc & req0_valid & ~arb1;
  assign req1_ready = can_acc & arb1;

  assign busy = (state_q == S_ISSUE) | (state_q == S_WAIT);
  assign fin_done = (state_q == S_WAIT) & eng_done;
  // cnt_q = cycles since acceptance; abort lands as it hits TIMEOUT_CYC-1
  assign fin_tmo = busy & (cnt_q == CNT_LAST) & ~fin_done;
  assign fin_err = ~fin_done | eng_ack_err;
  assign fin_rd =
    (fin_done & ~eng_ack_err & eng_cmd_q[RW_BIT]) ? eng_rdata : 8'h00;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      lg_q        <= 1'b1;
      cnt_q       <= '0;
      eng_valid_q <= 1'b0;
      eng_cmd_q   <= '0;
      eng_abort_q <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rd0_q       <= 8'h00;
      rd1_q       <= 8'h00;
    end else begin
      eng_abort_q <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      if (busy) cnt_q <= cnt_q + 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (req0_ready | req1_ready) begin
            state_q     <= S_ISSUE;
            eng_valid_q <= 1'b1;
            eng_cmd_q   <= req1_ready ? req1_cmd : req0_cmd;
            owner_q     <= req1_ready;
            lg_q        <= req1_ready;
            cnt_q       <= CNT_W'(1);
          end
        end
        S_ISSUE: begin
          if (!fin_tmo && eng_ready) begin
            state_q     <= S_WAIT;
            eng_valid_q <= 1'b0;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
        default: ;
      endcase
      if (fin_done | fin_tmo) begin
        state_q     <= S_RESP;
        eng_valid_q <= 1'b0;
        eng_abort_q <= fin_tmo;
        if (owner_q) begin
          done1_q <= 1'b1;
          err1_q  <= fin_err;
          rd1_q   <= fin_rd;
        end else begin
          done0_q <= 1'b1;
          err0_q  <= fin_err;
          rd0_q   <= fin_rd;
        end
      end
    end
  end

  assign eng_valid  = eng_valid_q;
  assign eng_cmd    = eng_cmd_q;
  assign eng_abort  = eng_abort_q;
  assign req0_done  = done0_q;
  assign req1_done  = done1_q;
  assign req0_err   = err0_q;
  assign req1_err   = err1_q;
  assign req0_rdata = rd0_q;
  assign req1_rdata = rd1_q;

endmodule

// File: tb/tb_i2c_access_arbiter.sv
// tb_i2c_access_arbiter: randomized and directed bench with a
// transaction-timeline reference model for the access arbiter.
module tb_i2c_access_arbiter;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_done;
  logic        req0_valid, req1_valid;
  logic [32:0] req0_cmd, req1_cmd;
  logic        req0_ready, req1_ready;
  logic        req0_done, req1_done;
  logic        req0_err, req1_err;
  logic [7:0]  req0_rdata, req1_rdata;
  logic        eng_valid;
  logic [32:0] eng_cmd;
  logic        eng_ready, eng_done, eng_ack_err;
  logic [7:0]  eng_rdata;
  logic        eng_abort;

  int n_chk = 0;
  int n_fail = 0;

  bit       lg;
  bit       h_err [2];
  bit [7:0] h_rd [2];

  always #5 clk = ~clk;

  i2c_access_arbiter #(.TIMEOUT_CYC(TMO), .CMD_W(33)) dut (
    .clk(clk), .rstn(rstn), .cfg_done(cfg_done),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd),
    .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_err(req0_err), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd),
    .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_err(req1_err), .req1_rdata(req1_rdata),
    .eng_valid(eng_valid), .eng_cmd(eng_cmd),
    .eng_ready(eng_ready), .eng_done(eng_done),
    .eng_ack_err(eng_ack_err), .eng_rdata(eng_rdata),
    .eng_abort(eng_abort)
  );

  task automatic check_eq(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] mk_cmd(input logic [7:0] dev,
                                         input logic rw,
                                         input logic [15:0] ra,
                                         input logic [7:0] wd);
    return {dev, rw, ra, wd};
  endfunction

  task automatic model_reset();
    lg = 1'b1;
    h_err[0] = 1'b0; h_err[1] = 1'b0;
    h_rd[0] = 8'h00; h_rd[1] = 8'h00;
  endtask

  task automatic quiet_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    eng_ready = 1'b0; eng_done = 1'b0;
    eng_ack_err = 1'b0; eng_rdata = 8'h00;
  endtask

  task automatic chk_zero(input string tag);
    check_eq({tag, ".eng_valid"}, eng_valid, 0);
    check_eq({tag, ".eng_cmd"}, eng_cmd, 0);
    check_eq({tag, ".eng_abort"}, eng_abort, 0);
    check_eq({tag, ".done0"}, req0_done, 0);
    check_eq({tag, ".done1"}, req1_done, 0);
    check_eq({tag, ".err0"}, req0_err, 0);
    check_eq({tag, ".err1"}, req1_err, 0);
    check_eq({tag, ".rd0"}, req0_rdata, 0);
    check_eq({tag, ".rd1"}, req1_rdata, 0);
    check_eq({tag, ".ready0"}, req0_ready, 0);
    check_eq({tag, ".ready1"}, req1_ready, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rstn = 1'b0;
    quiet_inputs();
    #1;
    chk_zero("reset");
    model_reset();
    @(posedge clk); #2;
    rstn = 1'b1;
  endtask

  // Idle cycles: cfg high with no requests, or cfg low with
  // requests that must never be granted.
  task automatic idle(input int n, input bit cfg, input bit only1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cfg_done = cfg;
      req0_valid = (cfg || only1) ? 1'b0 : 1'($urandom);
      req1_valid = cfg ? 1'b0 : (only1 ? 1'b1 : 1'($urandom));
      eng_ready = 1'($urandom);
      eng_done = 1'($urandom);
      eng_ack_err = 1'($urandom);
      eng_rdata = 8'($urandom);
      #1;
      check_eq("idle.ready0", req0_ready, 0);
      check_eq("idle.ready1", req1_ready, 0);
      check_eq("idle.eng_valid", eng_valid, 0);
      check_eq("idle.done", {req0_done, req1_done}, 0);
      check_eq("idle.abort", eng_abort, 0);
    end
  endtask

  // One transaction, timed in cycles after acceptance (cycle 0).
  // Engine takes the command at t_r and finishes dd cycles later.
  task automatic txn(input bit v0, input bit v1,
                     input logic [32:0] c0, input logic [32:0] c1,
                     input int t_r, input int dd,
                     input bit nack, input logic [7:0] rd,
                     input bit spur, input int rst_at);
    int w;
    int t_d;
    int t_fin;
    bit tmo;
    logic [32:0] cw;
    bit exp_err;
    logic [7:0] exp_rd;
    w = (v0 && v1) ? (lg ? 0 : 1) : (v1 ? 1 : 0);
    cw = (w == 1) ? c1 : c0;
    t_d = t_r + dd;
    tmo = (t_r > TMO - 2) || (t_d > TMO - 2);
    t_fin = tmo ? TMO - 1 : t_d + 1;
    exp_err = tmo ? 1'b1 : nack;
    exp_rd = (!tmo && !nack && cw[24]) ? rd : 8'h00;

    @(posedge clk); #1;
    cfg_done = 1'b1;
    req0_valid = v0; req1_valid = v1;
    req0_cmd = c0; req1_cmd = c1;
    eng_ready = 1'b0; eng_done = 1'b0;
    #1;
    check_eq("acc.ready0", req0_ready, v0 && w == 0);
    check_eq("acc.ready1", req1_ready, w == 1);
    check_eq("acc.done", {req0_done, req1_done}, 0);
    check_eq("hold.err0", req0_err, h_err[0]);
    check_eq("hold.err1", req1_err, h_err[1]);
    check_eq("hold.rd0", req0_rdata, h_rd[0]);
    check_eq("hold.rd1", req1_rdata, h_rd[1]);
    lg = (w == 1);

    for (int t = 1; t <= t_fin; t++) begin
      @(posedge clk); #1;
      cfg_done = 1'($urandom);
      eng_ready = (t == t_r);
      eng_done = (t == t_d) || (spur && t == 1);
      eng_ack_err = (t == t_d) ? nack : 1'($urandom);
      eng_rdata = (t == t_d) ? rd : 8'($urandom);
      if (t == rst_at) begin
        rstn = 1'b0;
        quiet_inputs();
        cfg_done = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(posedge clk); #2;
          check_eq("midrst.done", {req0_done, req1_done}, 0);
          check_eq("midrst.abort", eng_abort, 0);
          check_eq("midrst.eng_valid", eng_valid, 0);
        end
        return;
      end
      #1;
      check_eq("eng_valid", eng_valid, (t <= t_r) && (t < t_fin));
      check_eq("eng_cmd", eng_cmd, cw);
      check_eq("eng_abort", eng_abort, tmo && t == t_fin);
      check_eq("busy.ready", {req0_ready, req1_ready}, 0);
      check_eq(w == 1 ? "done1" : "done0",
               w == 1 ? req1_done : req0_done, t == t_fin);
      check_eq(w == 1 ? "done0.other" : "done1.other",
               w == 1 ? req0_done : req1_done, 0);
      if (t == t_fin) begin
        check_eq("resp.err", w == 1 ? req1_err : req0_err, exp_err);
        check_eq("resp.rdata",
                 w == 1 ? req1_rdata : req0_rdata, exp_rd);
        h_err[w] = exp_err;
        h_rd[w] = exp_rd;
      end
    end
  endtask

  initial begin
    int r;
    int t_r;
    int dd;
    bit v0;
    bit v1;
    rstn = 1'b0;
    cfg_done = 1'b0;
    req0_cmd = '0; req1_cmd = '0;
    quiet_inputs();
    model_reset();
    #2;
    chk_zero("por");
    @(posedge clk); #2;
    rstn = 1'b1;

    // read returning 0x02 after 50 cycles
    txn(1, 0, mk_cmd(8'h6C, 1, 16'h0000, 8'h00), '0,
        1, 49, 0, 8'h02, 0, 0);
    idle(3, 1, 0);

    // round robin from reset with both requesters held valid
    do_reset();
    for (int i = 0; i < 4; i++)
      txn(1, 1, mk_cmd(8'h10, 1, 16'(i), 8'h00),
          mk_cmd(8'h22, 0, 16'h0100 + 16'(i), 8'(i)),
          1 + i, 2 + i, 0, 8'hA0 + 8'(i), 0, 0);

    // cfg gating, then cfg rises with req1 waiting
    idle(100, 0, 1);
    txn(0, 1, '0, mk_cmd(8'h44, 1, 16'hBEEF, 8'h00),
        3, 5, 0, 8'h5A, 1, 0);

    // timeouts: engine never takes it, engine never finishes
    txn(1, 0, mk_cmd(8'h50, 1, 16'h0001, 8'h00), '0,
        200, 1, 0, 8'hFF, 0, 0);
    txn(0, 1, '0, mk_cmd(8'h52, 1, 16'h0002, 8'h00),
        4, 500, 0, 8'hEE, 0, 0);

    // NACK on a write and on a read
    txn(1, 0, mk_cmd(8'h20, 0, 16'h1234, 8'hAB), '0,
        3, 10, 1, 8'h55, 0, 0);
    txn(0, 1, '0, mk_cmd(8'h21, 1, 16'h4321, 8'h00),
        2, 6, 1, 8'h66, 0, 0);

    // eng_done on the last cycle before timeout wins
    txn(1, 0, mk_cmd(8'h30, 1, 16'h0003, 8'h00), '0,
        3, 59, 0, 8'h9A, 0, 0);
    txn(0, 1, '0, mk_cmd(8'h31, 1, 16'h0004, 8'h00),
        5, 57, 1, 8'h9B, 0, 0);

    // reset while waiting on the engine
    txn(1, 0, mk_cmd(8'h32, 1, 16'h0005, 8'h00), '0,
        2, 20, 0, 8'h77, 0, 10);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 2);
      v0 = (r != 1);
      v1 = (r != 0);
      t_r = ($urandom_range(0, 9) == 0) ?
            $urandom_range(60, 70) : $urandom_range(1, 6);
      dd = ($urandom_range(0, 7) == 0) ?
           $urandom_range(55, 65) : $urandom_range(1, 20);
      txn(v0, v1, 33'({$urandom, $urandom}),
          33'({$urandom, $urandom}), t_r, dd,
          1'($urandom), 8'($urandom), 1'($urandom), 0);
      idle($urandom_range(0, 3), 1'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
